// File: rtl/eth_gmii_frame_tx.sv
// AXI4-Stream to GMII/MII frame transmitter: preamble/SFD, zero padding, CRC32 FCS
// and inter-frame gap, with an MII nibble mode for 10/100 operation.
module eth_gmii_frame_tx #(
  parameter int DATA_WIDTH       = 8,
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] gmii_txd,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  input  logic                  clk_enable,
  input  logic                  mii_select,
  input  logic [7:0]            ifg_delay,
  output logic                  start_packet,
  output logic                  error_underflow
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_PAYLOAD  = 3'd2;
  localparam logic [2:0] S_PAD      = 3'd3;
  localparam logic [2:0] S_FCS      = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_IFG      = 3'd6;

  localparam logic [15:0] PAD_LEN = 16'(MIN_FRAME_LENGTH - 4);

  logic [2:0]  state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        nib_q, nib_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        start_packet_q, start_packet_d;
  logic        error_underflow_q, error_underflow_d;

  logic        slot;
  logic [7:0]  byte_sel;
  logic        en_sel, er_sel, sfd_sel, uf_sel;
  logic [15:0] frame_inc;
  logic [8:0]  ifg_next;
  logic [7:0]  ifg_eff;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // A byte slot is one enabled clk in GMII, or the second nibble clk in MII.
  assign slot = clk_enable && (!mii_select || nib_q);

  // Upstream handshake: a byte transfers on a clk where tvalid and tready are both high.
  // tready is a pure function of state and slot timing, never of tvalid.
  assign s_axis_tready = slot && ((state_q == S_PAYLOAD) || (state_q == S_DRAIN));

  assign frame_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
  assign ifg_next  = {1'b0, ifg_cnt_q} + 9'd1;
  assign ifg_eff   = (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
  assign fcs_word  = ~crc_q;

  always_comb begin
    state_d           = state_q;
    byte_cnt_d        = byte_cnt_q;
    frame_cnt_d       = frame_cnt_q;
    ifg_cnt_d         = ifg_cnt_q;
    crc_d             = crc_q;
    nib_d             = nib_q;
    hi_d              = hi_q;
    txd_d             = txd_q;
    tx_en_d           = tx_en_q;
    tx_er_d           = tx_er_q;
    start_packet_d    = start_packet_q;
    error_underflow_d = error_underflow_q;
    byte_sel          = 8'h00;
    en_sel            = 1'b0;
    er_sel            = 1'b0;
    sfd_sel           = 1'b0;
    uf_sel            = 1'b0;

    if (slot) begin
      case (state_q)
        S_IDLE: begin
          crc_d       = 32'hFFFFFFFF;
          frame_cnt_d = 16'd0;
          // The first preamble byte goes out in the same slot that sees tvalid, so a
          // back-to-back frame follows the gap with no extra idle slot.
          if (s_axis_tvalid) begin
            byte_sel   = 8'h55;
            en_sel     = 1'b1;
            byte_cnt_d = 3'd1;
            state_d    = S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          en_sel = 1'b1;
          if (byte_cnt_q == 3'd7) begin
            byte_sel = 8'hD5;
            sfd_sel  = 1'b1;
            state_d  = S_PAYLOAD;
          end else begin
            byte_sel   = 8'h55;
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
        S_PAYLOAD: begin
          en_sel = 1'b1;
          if (s_axis_tvalid) begin
            byte_sel    = s_axis_tdata[7:0];
            crc_d       = crc_step(crc_q, s_axis_tdata[7:0]);
            frame_cnt_d = frame_inc;
            if (s_axis_tlast) begin
              byte_cnt_d = 3'd0;
              ifg_cnt_d  = 8'd0;
              if (s_axis_tuser) begin
                er_sel  = 1'b1;
                state_d = S_IFG;
              end else if ((ENABLE_PADDING != 0) && (frame_inc < PAD_LEN)) begin
                state_d = S_PAD;
              end else begin
                state_d = S_FCS;
              end
            end
          end else begin
            er_sel  = 1'b1;
            uf_sel  = 1'b1;
            state_d = S_DRAIN;
          end
        end
        S_PAD: begin
          en_sel      = 1'b1;
          crc_d       = crc_step(crc_q, 8'h00);
          frame_cnt_d = frame_inc;
          if (frame_inc >= PAD_LEN) begin
            byte_cnt_d = 3'd0;
            state_d    = S_FCS;
          end
        end
        S_FCS: begin
          en_sel = 1'b1;
          case (byte_cnt_q[1:0])
            2'd0:    byte_sel = fcs_word[7:0];
            2'd1:    byte_sel = fcs_word[15:8];
            2'd2:    byte_sel = fcs_word[23:16];
            default: byte_sel = fcs_word[31:24];
          endcase
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            ifg_cnt_d = 8'd0;
            state_d   = S_IFG;
          end
        end
        S_DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            ifg_cnt_d = 8'd0;
            state_d   = S_IFG;
          end
        end
        S_IFG: begin
          ifg_cnt_d = ifg_next[7:0];
          if (ifg_next >= {1'b0, ifg_eff}) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (clk_enable) begin
      // Nibble phase parks at 0 while idle with nothing to send.
      if (!mii_select) begin
        nib_d = 1'b0;
      end else if ((state_q == S_IDLE) && !nib_q) begin
        nib_d = s_axis_tvalid;
      end else begin
        nib_d = !nib_q;
      end

      if (slot) begin
        txd_d             = mii_select ? {4'h0, byte_sel[3:0]} : byte_sel;
        hi_d              = byte_sel[7:4];
        tx_en_d           = en_sel;
        tx_er_d           = er_sel;
        start_packet_d    = sfd_sel;
        error_underflow_d = uf_sel;
      end else begin
        txd_d             = {4'h0, hi_q};
        start_packet_d    = 1'b0;
        error_underflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      byte_cnt_q        <= 3'd0;
      frame_cnt_q       <= 16'd0;
      ifg_cnt_q         <= 8'd0;
      crc_q             <= 32'hFFFFFFFF;
      nib_q             <= 1'b0;
      hi_q              <= 4'h0;
      txd_q             <= 8'h00;
      tx_en_q           <= 1'b0;
      tx_er_q           <= 1'b0;
      start_packet_q    <= 1'b0;
      error_underflow_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      byte_cnt_q        <= byte_cnt_d;
      frame_cnt_q       <= frame_cnt_d;
      ifg_cnt_q         <= ifg_cnt_d;
      crc_q             <= crc_d;
      nib_q             <= nib_d;
      hi_q              <= hi_d;
      txd_q             <= txd_d;
      tx_en_q           <= tx_en_d;
      tx_er_q           <= tx_er_d;
      start_packet_q    <= start_packet_d;
      error_underflow_q <= error_underflow_d;
    end
  end

  assign gmii_txd        = txd_q;
  assign gmii_tx_en      = tx_en_q;
  assign gmii_tx_er      = tx_er_q;
  assign start_packet    = start_packet_q;
  assign error_underflow = error_underflow_q;

endmodule
